// File: rtl/commit_buffer.sv
// ----------------------------------------------------------------------------
// commit_buffer
//
// Multi-lane commit stage between the core retire logic and the difftest
// InstrCommit / TrapEvent consumers. Up to LANES retire records per cycle are
// compacted in lane order and written into a DEPTH-entry circular FIFO. The
// FIFO drains one record per cycle under a valid/ready handshake. The block
// also keeps cycle and retired-instruction counters, flags records whose pc
// equals PC_START as skip, detects the trap instruction (opcode 7'h6b), emits
// a one-cycle trap pulse and halts until reset.
//
// Optional feature macro: COMMIT_BUF_BYPASS_EN
//   When defined, an empty FIFO plus a ready consumer lets the lowest valid
//   lane go straight to out_* in the same cycle. The remaining lanes are
//   written to the FIFO. When undefined there is no input-to-output
//   combinational path and the minimum latency is one cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         per-lane record valid, lane 0 oldest
//   in_pc/in_inst    per-lane pc / instruction word
//   in_wen/in_wdest  per-lane register write enable / destination
//   in_wdata         per-lane write data
//   in_ready         all lanes accepted this cycle
//   trap_code_i      a0[7:0], captured when the trap record pops
//   out_valid/ready  head record handshake
//   out_pc/inst/wen/wdest/wdata/skip  head record fields
//   trap_valid       one-cycle trap pulse
//   trap_code/pc     captured trap code and trap instruction pc
//   cycle_cnt        cycles since reset release (frozen while halted)
//   instr_cnt        records popped
//   halted           sticky stop after a trap
// ----------------------------------------------------------------------------
module commit_buffer #(
   parameter int unsigned    LANES    = 2,
   parameter int unsigned    DEPTH    = 8,
   parameter int unsigned    XLEN     = 64,
   parameter logic [XLEN-1:0] PC_START = 64'h0000_0000_8000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LANES-1:0]      in_valid,
   input  logic [LANES*XLEN-1:0] in_pc,
   input  logic [LANES*32-1:0]   in_inst,
   input  logic [LANES-1:0]      in_wen,
   input  logic [LANES*5-1:0]    in_wdest,
   input  logic [LANES*XLEN-1:0] in_wdata,
   output logic                  in_ready,
   input  logic [7:0]            trap_code_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [31:0]           out_inst,
   output logic                  out_wen,
   output logic [7:0]            out_wdest,
   output logic [XLEN-1:0]       out_wdata,
   output logic                  out_skip,
   output logic                  trap_valid,
   output logic [7:0]            trap_code,
   output logic [XLEN-1:0]       trap_pc,
   output logic [XLEN-1:0]       cycle_cnt,
   output logic [XLEN-1:0]       instr_cnt,
   output logic                  halted
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   // FIFO storage
   logic [XLEN-1:0] mem_pc_q    [DEPTH];
   logic [31:0]     mem_inst_q  [DEPTH];
   logic            mem_wen_q   [DEPTH];
   logic [4:0]      mem_wdest_q [DEPTH];
   logic [XLEN-1:0] mem_wdata_q [DEPTH];

   state_e          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [XLEN-1:0] instr_cnt_q, instr_cnt_d;
   logic            trap_valid_q, trap_valid_d;
   logic [7:0]      trap_code_q, trap_code_d;
   logic [XLEN-1:0] trap_pc_q, trap_pc_d;

   logic            halted_s;
   logic            in_ready_s;
   logic            bypass_s;
   logic            byp_taken_s;
   logic [LANES-1:0] lane_we_s;
   logic [CW-1:0]   lane_off_s [LANES];
   logic [CW-1:0]   push_cnt_s;
   logic [XLEN-1:0] byp_pc_s;
   logic [31:0]     byp_inst_s;
   logic            byp_wen_s;
   logic [4:0]      byp_wdest_s;
   logic [XLEN-1:0] byp_wdata_s;
   logic            out_valid_s;
   logic            pop_s;
   logic            pop_fifo_s;
   logic            trap_pop_s;
   logic [XLEN-1:0] head_pc_s;
   logic [31:0]     head_inst_s;
   logic            head_wen_s;
   logic [4:0]      head_wdest_s;
   logic [XLEN-1:0] head_wdata_s;

   assign halted_s = (state_q == ST_HALT);

   // Push acceptance: uses the pre-cycle count, a same-cycle pop is not credited
   always_comb begin
      in_ready_s = 1'b0;
      if (!halted_s && ((CW'(DEPTH) - count_q) >= CW'(LANES))) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = 1'b0;
      end
   end

   // Bypass qualification (feature build only)
   always_comb begin
      bypass_s = 1'b0;
`ifdef COMMIT_BUF_BYPASS_EN
      if ((count_q == '0) && !halted_s && in_ready_s && (in_valid != '0) && out_ready) begin
         bypass_s = 1'b1;
      end else begin
         bypass_s = 1'b0;
      end
`else
      bypass_s = 1'b0;
`endif
   end

   // Lane compaction: each written lane gets the next free slot offset; the
   // lowest valid lane is diverted to the output when bypassing
   always_comb begin
      lane_we_s   = '0;
      push_cnt_s  = '0;
      byp_taken_s = 1'b0;
      byp_pc_s    = '0;
      byp_inst_s  = 32'h0000_0000;
      byp_wen_s   = 1'b0;
      byp_wdest_s = 5'd0;
      byp_wdata_s = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_off_s[i] = '0;
      end
      if (in_ready_s) begin
         for (int i = 0; i < LANES; i++) begin
            if (in_valid[i]) begin
               if (bypass_s && !byp_taken_s) begin
                  byp_taken_s = 1'b1;
                  byp_pc_s    = in_pc[i*XLEN +: XLEN];
                  byp_inst_s  = in_inst[i*32 +: 32];
                  byp_wen_s   = in_wen[i];
                  byp_wdest_s = in_wdest[i*5 +: 5];
                  byp_wdata_s = in_wdata[i*XLEN +: XLEN];
               end else begin
                  lane_we_s[i]  = 1'b1;
                  lane_off_s[i] = push_cnt_s;
                  push_cnt_s    = push_cnt_s + CW'(1);
               end
            end else begin
               lane_we_s[i] = 1'b0;
            end
         end
      end else begin
         lane_we_s = '0;
      end
   end

   // Head record selection and pop / trap decode
   always_comb begin
      head_pc_s    = mem_pc_q[rd_ptr_q];
      head_inst_s  = mem_inst_q[rd_ptr_q];
      head_wen_s   = mem_wen_q[rd_ptr_q];
      head_wdest_s = mem_wdest_q[rd_ptr_q];
      head_wdata_s = mem_wdata_q[rd_ptr_q];
      if (bypass_s) begin
         head_pc_s    = byp_pc_s;
         head_inst_s  = byp_inst_s;
         head_wen_s   = byp_wen_s;
         head_wdest_s = byp_wdest_s;
         head_wdata_s = byp_wdata_s;
      end else begin
         head_pc_s    = mem_pc_q[rd_ptr_q];
      end
      out_valid_s = bypass_s || ((count_q != '0) && !halted_s);
      pop_s       = out_valid_s && out_ready;
      // A bypassed record never occupied a FIFO slot
      pop_fifo_s  = pop_s && !bypass_s;
      trap_pop_s  = pop_s && (head_inst_s[6:0] == 7'h6b);
   end

   // Run/halt state: next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (trap_pop_s) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_HALT;
      endcase
   end

   // Pointer, occupancy, counter and trap capture next-state
   always_comb begin
      wr_ptr_d     = wr_ptr_q + PW'(push_cnt_s);
      rd_ptr_d     = rd_ptr_q + {{(PW-1){1'b0}}, pop_fifo_s};
      count_d      = count_q + push_cnt_s - {{(CW-1){1'b0}}, pop_fifo_s};
      instr_cnt_d  = instr_cnt_q + {{(XLEN-1){1'b0}}, pop_s};
      cycle_cnt_d  = cycle_cnt_q;
      trap_valid_d = trap_pop_s;
      trap_code_d  = trap_code_q;
      trap_pc_d    = trap_pc_q;
      if (halted_s) begin
         cycle_cnt_d = cycle_cnt_q;
      end else begin
         cycle_cnt_d = cycle_cnt_q + {{(XLEN-1){1'b0}}, 1'b1};
      end
      if (trap_pop_s) begin
         // Everything still queued behind the trap is dropped
         count_d     = '0;
         trap_code_d = trap_code_i;
         trap_pc_d   = head_pc_s;
      end else begin
         trap_code_d = trap_code_q;
      end
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         cycle_cnt_q  <= '0;
         instr_cnt_q  <= '0;
         trap_valid_q <= 1'b0;
         trap_code_q  <= 8'h00;
         trap_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         cycle_cnt_q  <= cycle_cnt_d;
         instr_cnt_q  <= instr_cnt_d;
         trap_valid_q <= trap_valid_d;
         trap_code_q  <= trap_code_d;
         trap_pc_q    <= trap_pc_d;
      end
   end

   // FIFO storage writes: compacted lanes land at wr_ptr + offset, with wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem_pc_q[e]    <= '0;
            mem_inst_q[e]  <= 32'h0000_0000;
            mem_wen_q[e]   <= 1'b0;
            mem_wdest_q[e] <= 5'd0;
            mem_wdata_q[e] <= '0;
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_we_s[i]) begin
               mem_pc_q[wr_ptr_q + PW'(lane_off_s[i])]    <= in_pc[i*XLEN +: XLEN];
               mem_inst_q[wr_ptr_q + PW'(lane_off_s[i])]  <= in_inst[i*32 +: 32];
               mem_wen_q[wr_ptr_q + PW'(lane_off_s[i])]   <= in_wen[i];
               mem_wdest_q[wr_ptr_q + PW'(lane_off_s[i])] <= in_wdest[i*5 +: 5];
               mem_wdata_q[wr_ptr_q + PW'(lane_off_s[i])] <= in_wdata[i*XLEN +: XLEN];
            end
         end
      end
   end

   assign in_ready   = in_ready_s;
   assign out_valid  = out_valid_s;
   assign out_pc     = head_pc_s;
   assign out_inst   = head_inst_s;
   // x0 writes are architecturally meaningless, so never report them
   assign out_wen    = head_wen_s && (head_wdest_s != 5'd0);
   assign out_wdest  = {3'd0, head_wdest_s};
   assign out_wdata  = head_wdata_s;
   assign out_skip   = (head_pc_s == PC_START);
   assign trap_valid = trap_valid_q;
   assign trap_code  = trap_code_q;
   assign trap_pc    = trap_pc_q;
   assign cycle_cnt  = cycle_cnt_q;
   assign instr_cnt  = instr_cnt_q;
   assign halted     = halted_s;

endmodule

// File: tb/tb_commit_buffer.sv
// ----------------------------------------------------------------------------
// tb_commit_buffer
//
// Directed self-checking bench for commit_buffer (default build, LANES=2,
// DEPTH=8, XLEN=64). Inputs change and outputs are checked on the falling
// clock edge; the DUT updates on the rising edge.
// ----------------------------------------------------------------------------
module tb_commit_buffer;

   localparam int LANES = 2;
   localparam int XLEN  = 64;

   logic                  clk;
   logic                  rst_n;
   logic [LANES-1:0]      in_valid;
   logic [LANES*XLEN-1:0] in_pc;
   logic [LANES*32-1:0]   in_inst;
   logic [LANES-1:0]      in_wen;
   logic [LANES*5-1:0]    in_wdest;
   logic [LANES*XLEN-1:0] in_wdata;
   logic                  in_ready;
   logic [7:0]            trap_code_i;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       out_pc;
   logic [31:0]           out_inst;
   logic                  out_wen;
   logic [7:0]            out_wdest;
   logic [XLEN-1:0]       out_wdata;
   logic                  out_skip;
   logic                  trap_valid;
   logic [7:0]            trap_code;
   logic [XLEN-1:0]       trap_pc;
   logic [XLEN-1:0]       cycle_cnt;
   logic [XLEN-1:0]       instr_cnt;
   logic                  halted;

   int n_cmp;
   int n_err;
   int cyc;
   logic [63:0] frozen_cyc;

   commit_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_pc       (in_pc),
      .in_inst     (in_inst),
      .in_wen      (in_wen),
      .in_wdest    (in_wdest),
      .in_wdata    (in_wdata),
      .in_ready    (in_ready),
      .trap_code_i (trap_code_i),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst),
      .out_wen     (out_wen),
      .out_wdest   (out_wdest),
      .out_wdata   (out_wdata),
      .out_skip    (out_skip),
      .trap_valid  (trap_valid),
      .trap_code   (trap_code),
      .trap_pc     (trap_pc),
      .cycle_cnt   (cycle_cnt),
      .instr_cnt   (instr_cnt),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One rising edge, then back to the falling edge; counts cycles out of reset
   task automatic tick();
      @(posedge clk);
      if (rst_n) cyc = cyc + 1;
      @(negedge clk);
   endtask

   task automatic set_lane(input int l, input logic [63:0] pc, input logic [31:0] inst,
                           input logic wen, input logic [4:0] wdest, input logic [63:0] wdata);
      in_pc[l*XLEN +: XLEN]    = pc;
      in_inst[l*32 +: 32]      = inst;
      in_wen[l]                = wen;
      in_wdest[l*5 +: 5]       = wdest;
      in_wdata[l*XLEN +: XLEN] = wdata;
   endtask

   task automatic clear_lanes();
      in_valid = '0;
      in_pc    = '0;
      in_inst  = '0;
      in_wen   = '0;
      in_wdest = '0;
      in_wdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc   = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      cyc         = 0;
      out_ready   = 1'b0;
      trap_code_i = 8'h00;
      clear_lanes();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // ---- reset state ----
      check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("rst_cycle_cnt", cycle_cnt, 64'd0);
      check_val("rst_instr_cnt", instr_cnt, 64'd0);
      check_val("rst_halted", {63'd0, halted}, 64'd0);
      check_val("rst_trap_valid", {63'd0, trap_valid}, 64'd0);
      rst_n = 1'b1;
      check_val("rel_in_ready", {63'd0, in_ready}, 64'd1);

      // ---- single record, one cycle latency, skip flag ----
      out_ready = 1'b1;
      in_valid  = 2'b01;
      set_lane(0, 64'h0000_0000_8000_0000, 32'h0000_0513, 1'b0, 5'd0, 64'd0);
      tick();
      clear_lanes();
      check_val("t1_out_valid", {63'd0, out_valid}, 64'd1);
      check_val("t1_out_pc", out_pc, 64'h0000_0000_8000_0000);
      check_val("t1_out_inst", {32'd0, out_inst}, 64'h0000_0513);
      check_val("t1_out_skip", {63'd0, out_skip}, 64'd1);
      check_val("t1_instr_pre", instr_cnt, 64'd0);
      tick();
      check_val("t1_instr_post", instr_cnt, 64'd1);
      check_val("t1_empty", {63'd0, out_valid}, 64'd0);
      check_val("t1_cycle_cnt", cycle_cnt, 64'(cyc));

      // ---- fill to full with two lanes per cycle, then drain across the wrap ----
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_val("fill_in_ready", {63'd0, in_ready}, 64'd1);
         in_valid = 2'b11;
         for (int j = 0; j < 2; j++) begin
            set_lane(j, 64'h1000 + 64'(8 * (2 * k + j)), 32'h0000_0013 | 32'((2 * k + j) << 20),
                     1'b0, 5'd0, 64'd0);
         end
         tick();
      end
      check_val("full_in_ready", {63'd0, in_ready}, 64'd0);
      in_valid = 2'b11;
      set_lane(0, 64'h9999, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      set_lane(1, 64'h9998, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      tick();
      clear_lanes();
      check_val("full_head_kept", out_pc, 64'h1000);
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         check_val("drain_valid", {63'd0, out_valid}, 64'd1);
         check_val("drain_pc", out_pc, 64'h1000 + 64'(8 * n));
         check_val("drain_inst", {32'd0, out_inst}, 64'(32'h0000_0013 | 32'(n << 20)));
         tick();
      end
      check_val("drain_empty", {63'd0, out_valid}, 64'd0);
      check_val("drain_instr_cnt", instr_cnt, 64'd9);

      // ---- sparse valids keep program order ----
      out_ready = 1'b0;
      in_valid  = 2'b10;
      set_lane(0, 64'h0bad, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      set_lane(1, 64'h8000_0010, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      tick();
      in_valid = 2'b11;
      set_lane(0, 64'h8000_0020, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      set_lane(1, 64'h8000_0030, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      tick();
      clear_lanes();
      out_ready = 1'b1;
      check_val("sparse_pc0", out_pc, 64'h8000_0010);
      check_val("sparse_skip0", {63'd0, out_skip}, 64'd0);
      tick();
      check_val("sparse_pc1", out_pc, 64'h8000_0020);
      tick();
      check_val("sparse_pc2", out_pc, 64'h8000_0030);
      tick();
      check_val("sparse_empty", {63'd0, out_valid}, 64'd0);

      // ---- write enable masking for x0 ----
      out_ready = 1'b0;
      in_valid  = 2'b11;
      set_lane(0, 64'h3000, 32'h0000_0013, 1'b1, 5'd0, 64'hdead);
      set_lane(1, 64'h3004, 32'h0000_0013, 1'b1, 5'd5, 64'hbeef);
      tick();
      clear_lanes();
      check_val("wen_x0", {63'd0, out_wen}, 64'd0);
      check_val("wdest_x0", {56'd0, out_wdest}, 64'h00);
      check_val("wdata_x0", out_wdata, 64'hdead);
      out_ready = 1'b1;
      tick();
      check_val("wen_x5", {63'd0, out_wen}, 64'd1);
      check_val("wdest_x5", {56'd0, out_wdest}, 64'h05);
      check_val("wdata_x5", out_wdata, 64'hbeef);
      tick();
      check_val("wen_instr_cnt", instr_cnt, 64'd14);

      // ---- trap: pulse, capture, halt, discard, frozen cycle counter ----
      out_ready = 1'b0;
      in_valid  = 2'b11;
      set_lane(0, 64'h2000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      set_lane(1, 64'h2004, 32'h0000_006b, 1'b0, 5'd0, 64'd0);
      tick();
      in_valid = 2'b01;
      set_lane(0, 64'h2008, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      tick();
      clear_lanes();
      out_ready = 1'b1;
      check_val("trap_pc_first", out_pc, 64'h2000);
      tick();
      check_val("trap_pc_second", out_pc, 64'h2004);
      check_val("trap_not_yet", {63'd0, trap_valid}, 64'd0);
      trap_code_i = 8'h5a;
      tick();
      trap_code_i = 8'h00;
      check_val("trap_valid", {63'd0, trap_valid}, 64'd1);
      check_val("trap_pc", trap_pc, 64'h2004);
      check_val("trap_code", {56'd0, trap_code}, 64'h5a);
      check_val("trap_halted", {63'd0, halted}, 64'd1);
      check_val("trap_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("trap_in_ready", {63'd0, in_ready}, 64'd0);
      check_val("trap_instr_cnt", instr_cnt, 64'd16);
      check_val("trap_cycle_cnt", cycle_cnt, 64'(cyc));
      frozen_cyc = 64'(cyc);
      in_valid = 2'b11;
      set_lane(0, 64'h4000, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      set_lane(1, 64'h4004, 32'h0000_0013, 1'b0, 5'd0, 64'd0);
      tick();
      clear_lanes();
      tick();
      check_val("trap_pulse_end", {63'd0, trap_valid}, 64'd0);
      check_val("halt_cycle_frozen", cycle_cnt, frozen_cyc);
      check_val("halt_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("halt_instr_cnt", instr_cnt, 64'd16);
      check_val("halt_sticky", {63'd0, halted}, 64'd1);

      // ---- asynchronous reset with entries queued ----
      do_reset();
      check_val("rr_halted", {63'd0, halted}, 64'd0);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = (k == 3) ? 2'b01 : 2'b11;
         set_lane(0, 64'h5000 + 64'(16 * k), 32'h0000_006b, 1'b0, 5'd0, 64'd0);
         set_lane(1, 64'h5008 + 64'(16 * k), 32'h0000_006b, 1'b0, 5'd0, 64'd0);
         tick();
      end
      clear_lanes();
      check_val("q7_out_valid", {63'd0, out_valid}, 64'd1);
      check_val("q7_in_ready", {63'd0, in_ready}, 64'd0);
      #2;
      rst_n = 1'b0;
      cyc   = 0;
      #1;
      check_val("arst_out_valid", {63'd0, out_valid}, 64'd0);
      check_val("arst_in_ready", {63'd0, in_ready}, 64'd1);
      check_val("arst_instr_cnt", instr_cnt, 64'd0);
      check_val("arst_cycle_cnt", cycle_cnt, 64'd0);
      check_val("arst_trap_valid", {63'd0, trap_valid}, 64'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      check_val("post_rst_empty", {63'd0, out_valid}, 64'd0);
      check_val("post_rst_no_trap", {63'd0, trap_valid}, 64'd0);
      check_val("post_rst_cycle", cycle_cnt, 64'(cyc));
      tick();
      check_val("post_rst_instr", instr_cnt, 64'd0);
      check_val("post_rst_halted", {63'd0, halted}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
